// File: rtl/regfile_pkg.sv
// Shared register-file constants and core-wide index/word types.
package regfile_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register reservation bits, WAW hazard detection and reserved-register count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = NREGS_D,
  parameter int  NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD-1:0]    rbusy,
  output logic                rsv_hazard,
  output logic [AW:0]         busy_cnt
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_valid;
  logic             wb_hits_rsv;
  logic             rsv_acc;
  logic             wb_clr;
  logic [AW:0]      cnt_nxt;

  assign wb_valid    = wen && (waddr != '0);
  assign wb_hits_rsv = wen && (waddr == rsv_addr);

  // A writeback landing on the reserved index this cycle releases the old
  // reservation, so the new one is accepted rather than flagged as WAW.
  assign rsv_hazard = rsv_en && (rsv_addr != '0) && busy[rsv_addr] && !wb_hits_rsv;
  assign rsv_acc    = rsv_en && (rsv_addr != '0) && !rsv_hazard;
  assign wb_clr     = wb_valid && busy[waddr];

  // Same-index writeback+reserve: the clear is applied first, then the new reservation.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[waddr] = 1'b0;
    if (rsv_acc)  busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Incremental count: a clear and an accept on the same index cancel out.
  assign cnt_nxt = busy_cnt + (AW+1)'(rsv_acc) - (AW+1)'(wb_clr);

  // Reservation state and its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rbusy
    logic [AW-1:0] ra;
    assign ra       = raddr[i*AW +: AW];
    assign rbusy[i] = busy[ra] && !(wb_valid && (waddr == ra));
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NREAD combinational read ports with write bypass,
// hardwired-zero x0, and an attached reservation scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_D,
  parameter int  NREGS = NREGS_D,
  parameter int  NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_hazard,
  output logic [AW:0]           busy_cnt
);

  // Entry 0 is never written, so it stays at its reset value and folds away.
  logic [XLEN-1:0] regs [NREGS];

  // Data array: cleared on reset, written on writeback except to x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = raddr[i*AW +: AW];
    assign rd = (ra == '0)                 ? '0    :
                (wen && (waddr == ra))     ? wdata :
                                             regs[ra];
    assign rdata[i*XLEN +: XLEN] = rd;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .waddr      (waddr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .raddr      (raddr),
    .rbusy      (rbusy),
    .rsv_hazard (rsv_hazard),
    .busy_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default 32x32/2-read instance (a) and 16-entry/3-read instance (b).
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0]  raddr_a = '0;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic        wen_a = 1'b0;
  logic [4:0]  waddr_a = '0;
  logic [31:0] wdata_a = '0;
  logic        rsv_en_a = 1'b0;
  logic [4:0]  rsv_addr_a = '0;
  logic        rsv_hazard_a;
  logic [5:0]  busy_cnt_a;

  logic [11:0] raddr_b = '0;
  logic [95:0] rdata_b;
  logic [2:0]  rbusy_b;
  logic        wen_b = 1'b0;
  logic [3:0]  waddr_b = '0;
  logic [31:0] wdata_b = '0;
  logic        rsv_en_b = 1'b0;
  logic [3:0]  rsv_addr_b = '0;
  logic        rsv_hazard_b;
  logic [4:0]  busy_cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .rsv_en(rsv_en_a),
    .rsv_addr(rsv_addr_a), .rsv_hazard(rsv_hazard_a), .busy_cnt(busy_cnt_a)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .NREAD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .rsv_en(rsv_en_b),
    .rsv_addr(rsv_addr_b), .rsv_hazard(rsv_hazard_b), .busy_cnt(busy_cnt_b)
  );

  // Reference state: architectural contents and reservation flags per instance.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  function automatic logic [31:0] exp_rdata(int k, int ra, bit w, int wa, logic [31:0] wd);
    if (ra == 0) return 32'd0;
    if (w && wa == ra) return wd;
    return m_regs[k][ra];
  endfunction

  function automatic bit exp_rbusy(int k, int ra, bit w, int wa);
    return m_busy[k][ra] && !(w && wa == ra && wa != 0);
  endfunction

  function automatic bit exp_haz(int k, bit en, int ra, bit w, int wa);
    return en && ra != 0 && m_busy[k][ra] && !(w && wa == ra);
  endfunction

  function automatic int m_cnt(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
    return c;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // Reference state update at each edge; reset clears everything at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] <= '0;
          m_busy[k][i] <= 1'b0;
        end
    end else begin
      if (wen_a && waddr_a != 0) begin
        m_regs[0][waddr_a] <= wdata_a;
        m_busy[0][waddr_a] <= 1'b0;
      end
      if (rsv_en_a && rsv_addr_a != 0 &&
          !exp_haz(0, rsv_en_a, int'(rsv_addr_a), wen_a, int'(waddr_a)))
        m_busy[0][rsv_addr_a] <= 1'b1;
      if (wen_b && waddr_b != 0) begin
        m_regs[1][waddr_b] <= wdata_b;
        m_busy[1][waddr_b] <= 1'b0;
      end
      if (rsv_en_b && rsv_addr_b != 0 &&
          !exp_haz(1, rsv_en_b, int'(rsv_addr_b), wen_b, int'(waddr_b)))
        m_busy[1][rsv_addr_b] <= 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      int ra;
      ra = int'(raddr_a[p*5 +: 5]);
      check("a_rdata", 64'(rdata_a[p*32 +: 32]),
            64'(exp_rdata(0, ra, wen_a, int'(waddr_a), wdata_a)));
      check("a_rbusy", 64'(rbusy_a[p]), 64'(exp_rbusy(0, ra, wen_a, int'(waddr_a))));
    end
    check("a_hazard", 64'(rsv_hazard_a),
          64'(exp_haz(0, rsv_en_a, int'(rsv_addr_a), wen_a, int'(waddr_a))));
    check("a_busy_cnt", 64'(busy_cnt_a), 64'(m_cnt(0)));
    for (int p = 0; p < 3; p++) begin
      int ra;
      ra = int'(raddr_b[p*4 +: 4]);
      check("b_rdata", 64'(rdata_b[p*32 +: 32]),
            64'(exp_rdata(1, ra, wen_b, int'(waddr_b), wdata_b)));
      check("b_rbusy", 64'(rbusy_b[p]), 64'(exp_rbusy(1, ra, wen_b, int'(waddr_b))));
    end
    check("b_hazard", 64'(rsv_hazard_b),
          64'(exp_haz(1, rsv_en_b, int'(rsv_addr_b), wen_b, int'(waddr_b))));
    check("b_busy_cnt", 64'(busy_cnt_b), 64'(m_cnt(1)));
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    to_pos();
    to_pos();
    rst_n = 1'b1;

    // Fresh file reads zero and idle everywhere.
    for (int i = 0; i < 32; i++) begin
      raddr_a = {5'(i), 5'(i)};
      to_neg();
      check("dir_reset_rdata", rdata_a, 64'd0);
      check("dir_reset_rbusy", 64'(rbusy_a), 64'd0);
      check("dir_reset_cnt", 64'(busy_cnt_a), 64'd0);
      to_pos();
    end

    // Bypass then array read of x5.
    wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr_a = {5'd0, 5'd5};
    to_neg();
    check("dir_bypass_x5", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    to_pos();
    wen_a = 1'b0;
    to_neg();
    check("dir_array_x5", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    to_pos();

    // x0 stays zero.
    wen_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234; raddr_a = {5'd0, 5'd0};
    to_neg();
    check("dir_x0_bypass", 64'(rdata_a[31:0]), 64'd0);
    to_pos();
    wen_a = 1'b0;
    to_neg();
    check("dir_x0_array", 64'(rdata_a[31:0]), 64'd0);
    to_pos();

    // Reserve x7, retry (WAW), then writeback.
    rsv_en_a = 1'b1; rsv_addr_a = 5'd7;
    to_neg();
    check("dir_rsv7_haz", 64'(rsv_hazard_a), 64'd0);
    to_pos();
    rsv_en_a = 1'b0; raddr_a = {5'd7, 5'd0};
    to_neg();
    check("dir_rsv7_rbusy1", 64'(rbusy_a[1]), 64'd1);
    check("dir_rsv7_cnt", 64'(busy_cnt_a), 64'd1);
    to_pos();
    rsv_en_a = 1'b1;
    to_neg();
    check("dir_rsv7_again_haz", 64'(rsv_hazard_a), 64'd1);
    to_pos();
    rsv_en_a = 1'b0;
    to_neg();
    check("dir_rsv7_again_cnt", 64'(busy_cnt_a), 64'd1);
    to_pos();
    wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h55;
    to_neg();
    check("dir_wb7_rbusy1", 64'(rbusy_a[1]), 64'd0);
    check("dir_wb7_rdata1", 64'(rdata_a[63:32]), 64'h55);
    to_pos();
    wen_a = 1'b0;
    to_neg();
    check("dir_wb7_cnt", 64'(busy_cnt_a), 64'd0);
    check("dir_wb7_array", 64'(rdata_a[63:32]), 64'h55);
    to_pos();

    // Reserve x3, then same-cycle writeback and re-reserve of x3.
    rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
    to_pos();
    wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hA5A5;
    to_neg();
    check("dir_x3_same_haz", 64'(rsv_hazard_a), 64'd0);
    to_pos();
    wen_a = 1'b0; rsv_en_a = 1'b0; raddr_a = {5'd0, 5'd3};
    to_neg();
    check("dir_x3_rbusy0", 64'(rbusy_a[0]), 64'd1);
    check("dir_x3_cnt", 64'(busy_cnt_a), 64'd1);
    check("dir_x3_data", 64'(rdata_a[31:0]), 64'hA5A5);
    to_pos();

    // Writeback to an unreserved register leaves the count alone.
    wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h99;
    to_pos();
    wen_a = 1'b0; raddr_a = {5'd9, 5'd3};
    to_neg();
    check("dir_x9_cnt", 64'(busy_cnt_a), 64'd1);
    check("dir_x9_data", 64'(rdata_a[63:32]), 64'h99);
    to_pos();

    // Reserve x1..x31 (x3 already held, so that one is refused).
    for (int i = 1; i < 32; i++) begin
      rsv_en_a = 1'b1; rsv_addr_a = 5'(i);
      to_pos();
    end
    rsv_en_a = 1'b0;
    to_neg();
    check("dir_all_cnt", 64'(busy_cnt_a), 64'd31);
    to_pos();

    // Asynchronous reset between edges.
    raddr_a = {5'd7, 5'd5};
    #1;
    check("dir_pre_rst_rdata", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("dir_rst_cnt", 64'(busy_cnt_a), 64'd0);
    check("dir_rst_rbusy", 64'(rbusy_a), 64'd0);
    check("dir_rst_rdata", rdata_a, 64'd0);
    to_pos();
    rst_n = 1'b1;

    // First edge after release writes; busy stays clear.
    wen_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h44; raddr_a = {5'd0, 5'd4};
    to_pos();
    wen_a = 1'b0;
    to_neg();
    check("dir_post_rst_data", 64'(rdata_a[31:0]), 64'h44);
    check("dir_post_rst_rbusy", 64'(rbusy_a[0]), 64'd0);
    check("dir_post_rst_cnt", 64'(busy_cnt_a), 64'd0);
    to_pos();

    // Random traffic on both instances; instance b reads three distinct indices.
    for (int c = 0; c < 1000; c++) begin
      int r0, r1, r2;
      r0 = $urandom_range(0, 15);
      r1 = (r0 + 1 + $urandom_range(0, 14)) % 16;
      r2 = $urandom_range(0, 15);
      while (r2 == r0 || r2 == r1) r2 = (r2 + 1) % 16;
      raddr_b    = {4'(r2), 4'(r1), 4'(r0)};
      wen_b      = 1'($urandom_range(0, 1));
      waddr_b    = 4'($urandom_range(0, 15));
      wdata_b    = $urandom;
      rsv_en_b   = 1'($urandom_range(0, 1));
      rsv_addr_b = 4'($urandom_range(0, 15));
      raddr_a    = 10'($urandom_range(0, 1023));
      wen_a      = 1'($urandom_range(0, 1));
      waddr_a    = 5'($urandom_range(0, 31));
      wdata_a    = $urandom;
      rsv_en_a   = 1'($urandom_range(0, 1));
      rsv_addr_a = 5'($urandom_range(0, 31));
      to_pos();
    end
    wen_a = 1'b0; rsv_en_a = 1'b0; wen_b = 1'b0; rsv_en_b = 1'b0;
    to_neg();
    to_pos();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
